// File: rtl/sad_report_pkg.sv
// Shared constants, transmitter state encoding and byte-extraction helper
// for the SAD result reporter.
package sad_report_pkg;

  localparam int TRIPLE_W    = 96;
  localparam int FRAME_BYTES = 13;
  localparam int DATA_BYTES  = FRAME_BYTES - 1;

  localparam logic [7:0] HDR_BYTE = 8'hA5;

  typedef logic [TRIPLE_W-1:0] triple_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
  } tx_state_t;

  // Byte idx of the {X,Y,FINALSAD} triple, idx 0 being the X most-significant byte.
  function automatic logic [7:0] triple_byte(input triple_t t, input logic [3:0] idx);
    triple_t sh;
    sh = t >> (7'd88 - {idx, 3'b000});
    return sh[7:0];
  endfunction

endpackage

// File: rtl/sad_report_fifo.sv
// Small synchronous FIFO with full/empty flags; a push and a pop on the same
// edge both succeed even when full.
module sad_report_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 96
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
               (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    rdata    = mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/sad_result_reporter.sv
// Debounces the processor's {X,Y,FINALSAD} result, buffers each new stable
// triple and streams it out as a 13-byte frame (0xA5 header, then MSB first).
module sad_result_reporter
  import sad_report_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] X,
  input  logic [31:0] Y,
  input  logic [31:0] FINALSAD,
  input  logic        ByteReady,
  output logic [7:0]  ByteOut,
  output logic        ByteValid,
  output logic        Overflow,
  output logic [7:0]  ResultCount
);

  localparam logic [3:0] STABLE   = 4'(STABLE_CYCLES);
  localparam logic [3:0] LAST_IDX = 4'(DATA_BYTES - 1);

  triple_t    sample_q, sample_d;
  logic [3:0] stab_cnt_q, stab_cnt_d;
  triple_t    last_q, last_d;
  logic       overflow_q, overflow_d;
  logic [7:0] count_q, count_d;
  tx_state_t  state_q, state_d;
  logic [3:0] idx_q, idx_d;
  triple_t    frame_q, frame_d;

  logic    commit;
  logic    push;
  logic    pop;
  logic    fifo_full;
  logic    fifo_empty;
  triple_t fifo_head;

  // A commit fires once per stable run, on the edge the counter first saturates.
  always_comb begin
    sample_d = {X, Y, FINALSAD};
    if (sample_d != sample_q) begin
      stab_cnt_d = 4'd1;
    end else if (stab_cnt_q < STABLE) begin
      stab_cnt_d = stab_cnt_q + 4'd1;
    end else begin
      stab_cnt_d = stab_cnt_q;
    end
    commit     = (stab_cnt_d == STABLE) && (stab_cnt_q != STABLE) &&
                 (sample_d != last_q);
    last_d     = commit ? sample_d : last_q;
    push       = commit && (!fifo_full || pop);
    overflow_d = overflow_q | (commit & ~push);
    count_d    = push ? count_q + 8'd1 : count_q;
  end

  sad_report_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(TRIPLE_W)
  ) u_fifo (
    .clk  (Clk),
    .rst_n(Reset),
    .push (push),
    .pop  (pop),
    .wdata(sample_d),
    .rdata(fifo_head),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  // Handshake: ByteOut/ByteValid hold steady until an edge with
  // ByteValid && ByteReady, which consumes the byte and advances the frame.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    frame_d   = frame_q;
    pop       = 1'b0;
    ByteOut   = 8'h00;
    ByteValid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          state_d = ST_HDR;
          frame_d = fifo_head;
          idx_d   = 4'd0;
        end
      end
      ST_HDR: begin
        ByteValid = 1'b1;
        ByteOut   = HDR_BYTE;
        if (ByteReady) begin
          state_d = ST_DATA;
          idx_d   = 4'd0;
        end
      end
      ST_DATA: begin
        ByteValid = 1'b1;
        ByteOut   = triple_byte(frame_q, idx_q);
        if (ByteReady) begin
          if (idx_q == LAST_IDX) begin
            pop     = 1'b1;
            state_d = ST_IDLE;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      sample_q   <= '0;
      stab_cnt_q <= '0;
      last_q     <= '0;
      overflow_q <= 1'b0;
      count_q    <= '0;
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      frame_q    <= '0;
    end else begin
      sample_q   <= sample_d;
      stab_cnt_q <= stab_cnt_d;
      last_q     <= last_d;
      overflow_q <= overflow_d;
      count_q    <= count_d;
      state_q    <= state_d;
      idx_q      <= idx_d;
      frame_q    <= frame_d;
    end
  end

  assign Overflow    = overflow_q;
  assign ResultCount = count_q;

endmodule
